id_ex_pipeline_reg: RTL and testbench

ID/EX pipeline boundary of the 5-stage RV32I core: registers the 11-bit decode control word and the operand/address fields produced in ID, and presents them to EX one cycle later. It owns load-use hazard detection: it raises a stall toward PC/IF-ID and inserts a bubble into EX. It also honours a branch/jump flush from EX and a global step enable from the debug unit, and keeps a saturating count of inserted bubbles.

---
 rtl/id_ex_pipeline_reg.sv | 162 ++++++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core: carries decode results into EX,
// detects load-use hazards (stall + bubble), honours EX flush and debug step enable.
module id_ex_pipeline_reg #(
    parameter int NB_CTRL = 11,
    parameter int NB_DATA = 32,
    parameter int NB_PC   = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CNT  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_PC-1:0]   i_pc,
    input  logic [NB_DATA-1:0] i_rs1_data,
    input  logic [NB_DATA-1:0] i_rs2_data,
    input  logic [NB_DATA-1:0] i_imm,
    input  logic [NB_REG-1:0]  i_rs1_addr,
    input  logic [NB_REG-1:0]  i_rs2_addr,
    input  logic [NB_REG-1:0]  i_rd_addr,
    input  logic [2:0]         i_func3,
    input  logic               i_func7_b5,
    output logic               o_valid,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_PC-1:0]   o_pc,
    output logic [NB_DATA-1:0] o_rs1_data,
    output logic [NB_DATA-1:0] o_rs2_data,
    output logic [NB_DATA-1:0] o_imm,
    output logic [NB_REG-1:0]  o_rs1_addr,
    output logic [NB_REG-1:0]  o_rs2_addr,
    output logic [NB_REG-1:0]  o_rd_addr,
    output logic [2:0]         o_func3,
    output logic               o_func7_b5,
    output logic               o_stall,
    output logic [NB_CNT-1:0]  o_bubble_cnt
);

    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_ALU_SRC   = 3;
    localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};
    localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

    logic               valid_q,      valid_d;
    logic [NB_CTRL-1:0] ctrl_q,       ctrl_d;
    logic [NB_PC-1:0]   pc_q,         pc_d;
    logic [NB_DATA-1:0] rs1_data_q,   rs1_data_d;
    logic [NB_DATA-1:0] rs2_data_q,   rs2_data_d;
    logic [NB_DATA-1:0] imm_q,        imm_d;
    logic [NB_REG-1:0]  rs1_addr_q,   rs1_addr_d;
    logic [NB_REG-1:0]  rs2_addr_q,   rs2_addr_d;
    logic [NB_REG-1:0]  rd_addr_q,    rd_addr_d;
    logic [2:0]         func3_q,      func3_d;
    logic               func7_b5_q,   func7_b5_d;
    logic [NB_CNT-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic use_rs2_s;
    logic hz_s;

    // Load-use detection: EX load whose destination is read by the ID instruction.
    always_comb begin
        use_rs2_s = ~i_ctrl[CTRL_ALU_SRC] | i_ctrl[CTRL_MEM_WRITE];
        hz_s      = valid_q & ctrl_q[CTRL_MEM_READ] & (rd_addr_q != {NB_REG{1'b0}}) & i_valid &
                    ((rd_addr_q == i_rs1_addr) | (use_rs2_s & (rd_addr_q == i_rs2_addr)));
        o_stall   = hz_s & ~i_flush;
    end

    // Next-state selection: hold when disabled, flush beats bubble, bubble beats load.
    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        pc_d         = pc_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        imm_d        = imm_q;
        rs1_addr_d   = rs1_addr_q;
        rs2_addr_d   = rs2_addr_q;
        rd_addr_d    = rd_addr_q;
        func3_d      = func3_q;
        func7_b5_d   = func7_b5_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!i_en) begin
            bubble_cnt_d = bubble_cnt_q;
        end else if (i_flush || hz_s) begin
            valid_d    = 1'b0;
            ctrl_d     = {NB_CTRL{1'b0}};
            pc_d       = {NB_PC{1'b0}};
            rs1_data_d = {NB_DATA{1'b0}};
            rs2_data_d = {NB_DATA{1'b0}};
            imm_d      = {NB_DATA{1'b0}};
            rs1_addr_d = {NB_REG{1'b0}};
            rs2_addr_d = {NB_REG{1'b0}};
            rd_addr_d  = {NB_REG{1'b0}};
            func3_d    = 3'b000;
            func7_b5_d = 1'b0;
            if (!i_flush && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
            end else begin
                bubble_cnt_d = bubble_cnt_q;
            end
        end else begin
            valid_d    = i_valid;
            ctrl_d     = i_ctrl;
            pc_d       = i_pc;
            rs1_data_d = i_rs1_data;
            rs2_data_d = i_rs2_data;
            imm_d      = i_imm;
            rs1_addr_d = i_rs1_addr;
            rs2_addr_d = i_rs2_addr;
            rd_addr_d  = i_rd_addr;
            func3_d    = i_func3;
            func7_b5_d = i_func7_b5;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q      <= 1'b0;
            ctrl_q       <= {NB_CTRL{1'b0}};
            pc_q         <= {NB_PC{1'b0}};
            rs1_data_q   <= {NB_DATA{1'b0}};
            rs2_data_q   <= {NB_DATA{1'b0}};
            imm_q        <= {NB_DATA{1'b0}};
            rs1_addr_q   <= {NB_REG{1'b0}};
            rs2_addr_q   <= {NB_REG{1'b0}};
            rd_addr_q    <= {NB_REG{1'b0}};
            func3_q      <= 3'b000;
            func7_b5_q   <= 1'b0;
            bubble_cnt_q <= {NB_CNT{1'b0}};
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            pc_q         <= pc_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            rs1_addr_q   <= rs1_addr_d;
            rs2_addr_q   <= rs2_addr_d;
            rd_addr_q    <= rd_addr_d;
            func3_q      <= func3_d;
            func7_b5_q   <= func7_b5_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_ctrl       = ctrl_q;
    assign o_pc         = pc_q;
    assign o_rs1_data   = rs1_data_q;
    assign o_rs2_data   = rs2_data_q;
    assign o_imm        = imm_q;
    assign o_rs1_addr   = rs1_addr_q;
    assign o_rs2_addr   = rs2_addr_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_func3      = func3_q;
    assign o_func7_b5   = func7_b5_q;
    assign o_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Bench for id_ex_pipeline_reg: directed instruction sequences, an instruction-level
// model of the EX slot checked every cycle, plus literal expectations at key points.
module tb_id_ex_pipeline_reg;

    localparam int NB_CNT  = 2;
    localparam int CNT_SAT = 3;

    localparam logic [10:0] C_ADD  = 11'h181;
    localparam logic [10:0] C_LW   = 11'h61B;
    localparam logic [10:0] C_ADDI = 11'h189;

    logic        clk = 1'b0;
    logic        rst_n, en, flush, valid;
    logic [10:0] ctrl;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [2:0]  func3;
    logic        func7_b5;

    logic        o_valid, o_func7_b5, o_stall;
    logic [10:0] o_ctrl;
    logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic [2:0]  o_func3;
    logic [NB_CNT-1:0] o_bubble_cnt;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model of what sits in EX, as one instruction record
    typedef struct packed {
        logic        valid;
        logic [10:0] ctrl;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1_addr, rs2_addr, rd_addr;
        logic [2:0]  func3;
        logic        func7_b5;
    } instr_t;

    instr_t ex_m = '0;
    int     bubbles_m = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_reg #(.NB_CNT(NB_CNT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_flush(flush), .i_valid(valid),
        .i_ctrl(ctrl), .i_pc(pc), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_imm(imm),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .i_rd_addr(rd_addr),
        .i_func3(func3), .i_func7_b5(func7_b5),
        .o_valid(o_valid), .o_ctrl(o_ctrl), .o_pc(o_pc), .o_rs1_data(o_rs1_data),
        .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_rs1_addr(o_rs1_addr),
        .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr), .o_func3(o_func3),
        .o_func7_b5(o_func7_b5), .o_stall(o_stall), .o_bubble_cnt(o_bubble_cnt)
    );

    function automatic instr_t id_instr();
        instr_t t;
        t = '{valid, ctrl, pc, rs1_data, rs2_data, imm, rs1_addr, rs2_addr, rd_addr, func3, func7_b5};
        return t;
    endfunction

    // does the instruction in ID need the value being loaded by the instruction in EX?
    function automatic bit load_use(instr_t ex, instr_t id);
        bit ex_is_load, reads_rs2;
        ex_is_load = ex.valid && ex.ctrl[1] && ex.rd_addr != 5'd0;
        reads_rs2  = !id.ctrl[3] || id.ctrl[2];
        return ex_is_load && id.valid &&
               (ex.rd_addr == id.rs1_addr || (reads_rs2 && ex.rd_addr == id.rs2_addr));
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model advances on each rising edge using the inputs driven for that cycle
    always @(posedge clk) begin
        if (!rst_n) begin
            ex_m      = '0;
            bubbles_m = 0;
        end else if (en) begin
            if (flush) begin
                ex_m = '0;
            end else if (load_use(ex_m, id_instr())) begin
                ex_m      = '0;
                bubbles_m = (bubbles_m < CNT_SAT) ? bubbles_m + 1 : CNT_SAT;
            end else begin
                ex_m = id_instr();
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid",    64'(o_valid),    64'(ex_m.valid));
            chk("ctrl",     64'(o_ctrl),     64'(ex_m.ctrl));
            chk("pc",       64'(o_pc),       64'(ex_m.pc));
            chk("rs1_data", 64'(o_rs1_data), 64'(ex_m.rs1_data));
            chk("rs2_data", 64'(o_rs2_data), 64'(ex_m.rs2_data));
            chk("imm",      64'(o_imm),      64'(ex_m.imm));
            chk("rs1_addr", 64'(o_rs1_addr), 64'(ex_m.rs1_addr));
            chk("rs2_addr", 64'(o_rs2_addr), 64'(ex_m.rs2_addr));
            chk("rd_addr",  64'(o_rd_addr),  64'(ex_m.rd_addr));
            chk("func3",    64'(o_func3),    64'(ex_m.func3));
            chk("func7_b5", 64'(o_func7_b5), 64'(ex_m.func7_b5));
            chk("stall",    64'(o_stall),    64'(load_use(ex_m, id_instr()) && !flush));
            chk("bubbles",  64'(o_bubble_cnt), 64'(bubbles_m));
        end
    end

    task automatic set_in(logic v, logic [10:0] c, logic [31:0] p,
                          logic [4:0] r1, logic [4:0] r2, logic [4:0] rd);
        valid    = v;
        ctrl     = c;
        pc       = p;
        rs1_addr = r1;
        rs2_addr = r2;
        rd_addr  = rd;
        rs1_data = {p[15:0], 16'h1111};
        rs2_data = {16'h2222, p[15:0]};
        imm      = ~p;
        func3    = p[4:2];
        func7_b5 = p[2];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; flush = 1'b0;
        set_in(1'b1, C_LW, 32'h1234, 5'd3, 5'd4, 5'd7);
        tick();
        tick();
        chk_en = 1'b1;
        settle();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ctrl",  64'(o_ctrl),  64'd0);
        chk("rst_pc",    64'(o_pc),    64'd0);
        chk("rst_cnt",   64'(o_bubble_cnt), 64'd0);
        chk("rst_stall", 64'(o_stall), 64'd0);

        // pass-through of an R-type
        rst_n = 1'b1;
        set_in(1'b1, C_ADD, 32'h40, 5'd1, 5'd2, 5'd5);
        tick();
        chk("pt_ctrl",  64'(o_ctrl),    64'h181);
        chk("pt_pc",    64'(o_pc),      64'h40);
        chk("pt_rd",    64'(o_rd_addr), 64'd5);
        chk("pt_valid", 64'(o_valid),   64'd1);

        // load-use on rs2
        set_in(1'b1, C_LW, 32'h44, 5'd2, 5'd0, 5'd7);
        tick();
        set_in(1'b1, C_ADD, 32'h48, 5'd3, 5'd7, 5'd8);
        settle();
        chk("lu_stall", 64'(o_stall), 64'd1);
        tick();
        chk("lu_bub_ctrl",  64'(o_ctrl),  64'd0);
        chk("lu_bub_valid", 64'(o_valid), 64'd0);
        chk("lu_bub_cnt",   64'(o_bubble_cnt), 64'd1);
        chk("lu_stall_clr", 64'(o_stall), 64'd0);
        tick();
        chk("lu_add_ctrl", 64'(o_ctrl),    64'h181);
        chk("lu_add_rd",   64'(o_rd_addr), 64'd8);

        // no hazard through x0, nor through an unused rs2 field
        set_in(1'b1, C_LW, 32'h4C, 5'd2, 5'd0, 5'd0);
        tick();
        set_in(1'b1, C_ADD, 32'h50, 5'd0, 5'd0, 5'd9);
        settle();
        chk("x0_stall", 64'(o_stall), 64'd0);
        set_in(1'b1, C_LW, 32'h54, 5'd2, 5'd0, 5'd7);
        tick();
        set_in(1'b1, C_ADDI, 32'h58, 5'd3, 5'd7, 5'd10);
        settle();
        chk("addi_stall", 64'(o_stall), 64'd0);
        tick();
        chk("addi_ctrl", 64'(o_ctrl), 64'h189);

        // invalid slot still loads its fields
        set_in(1'b0, 11'h000, 32'h5C, 5'd7, 5'd7, 5'd0);
        tick();
        chk("inv_valid", 64'(o_valid), 64'd0);
        chk("inv_pc",    64'(o_pc),    64'h5C);

        // flush beats load-use
        set_in(1'b1, C_LW, 32'h60, 5'd2, 5'd0, 5'd7);
        tick();
        set_in(1'b1, C_ADD, 32'h64, 5'd3, 5'd7, 5'd8);
        flush = 1'b1;
        settle();
        chk("fl_stall", 64'(o_stall), 64'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid", 64'(o_valid), 64'd0);
        chk("fl_pc",    64'(o_pc),    64'd0);
        chk("fl_cnt",   64'(o_bubble_cnt), 64'd1);

        // disabled with hazard pending: frozen, stall still shown
        set_in(1'b1, C_LW, 32'h68, 5'd2, 5'd0, 5'd7);
        tick();
        set_in(1'b1, C_ADD, 32'h6C, 5'd7, 5'd1, 5'd8);
        en = 1'b0;
        tick();
        tick();
        chk("en_ctrl",  64'(o_ctrl),    64'h61B);
        chk("en_rd",    64'(o_rd_addr), 64'd7);
        chk("en_cnt",   64'(o_bubble_cnt), 64'd1);
        chk("en_stall", 64'(o_stall),   64'd1);
        en = 1'b1;
        tick();
        chk("en_bub_cnt", 64'(o_bubble_cnt), 64'd2);
        tick();

        // saturation of the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, C_LW, 32'h100 + 32'(k * 16), 5'd2, 5'd0, 5'd7);
            tick();
            set_in(1'b1, C_ADD, 32'h108 + 32'(k * 16), 5'd7, 5'd7, 5'd8);
            tick();
            tick();
        end
        chk("sat_cnt", 64'(o_bubble_cnt), 64'd3);

        // reset in the middle of a stall
        set_in(1'b1, C_LW, 32'h200, 5'd2, 5'd0, 5'd7);
        tick();
        set_in(1'b1, C_ADD, 32'h204, 5'd7, 5'd0, 5'd8);
        rst_n = 1'b0;
        tick();
        chk("rs_valid", 64'(o_valid), 64'd0);
        chk("rs_cnt",   64'(o_bubble_cnt), 64'd0);
        chk("rs_stall", 64'(o_stall), 64'd0);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
